mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage between EXE and WB.
- Accepts the EXE bus and tracks any data-SRAM request that EXE already issued for the instruction.
- Waits for the response, extracts and extends load data, then presents the WB bus.
- Discards responses belonging to instructions flushed by a WB exception or ertn. Drives a forwarding/blocking bus back to ID.

Parameters:
- PAY_W, 103: width of the exception/CSR payload passed through untouched to WB.
- DISC_W, 2: width of the discard counter for stale responses.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- ms_allowin  out  1  stage can accept from EXE
- es_to_ms_valid  in  1  EXE bus valid
- es_to_ms_bus  in  PAY_W+76  {payload[PAY_W], ld_op[3], addr_lo[2], req_issued, gr_we, dest[5], alu_result[32], pc[32]}
- ws_allowin  in  1  WB can accept
- ms_to_ws_valid  out  1  WB bus valid
- ms_to_ws_bus  out  PAY_W+70  {payload, gr_we, dest, final_result, pc}
- data_sram_data_ok  in  1  read/write response strobe
- data_sram_rdata  in  32  read data
- wb_flush  in  1  wb_ex or wb_ertn from WB
- es_flush_req  in  1  EXE holds an issued request that is being flushed this cycle
- ms_fwd_bus  out  40  {ms_valid, pending_load, gr_we&ms_valid, dest, final_result}

Behaviour:
- Reset (async, resetn=0):
  - ms_valid=0, state=IDLE, discard_cnt=0, rdata_buf_v=0.
  - Outputs: ms_allowin=1, ms_to_ws_valid=0, ms_fwd_bus=0.
- Pipeline control:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - The bus register loads when es_to_ms_valid && ms_allowin.
  - ms_to_ws_valid = ms_valid && ms_ready_go.
- States: IDLE, WAIT, HOLD.
  - IDLE to WAIT: an instruction with req_issued=1 is accepted. If data_ok arrives in the same cycle it targets the older instruction or the discard counter, never the new entry.
  - WAIT to IDLE: data_ok arrives with discard_cnt==0 and ws_allowin=1. The stage is ready_go that cycle, data passes straight through, and a new instruction may be accepted the same cycle.
  - WAIT to HOLD: data_ok arrives with ws_allowin=0. Capture rdata in rdata_buf and set rdata_buf_v.
  - HOLD to IDLE: on ws_allowin.
- ms_ready_go = !req_issued || state==HOLD || (state==WAIT && data_ok && discard_cnt==0).
- Discard:
  - Any data_ok seen while discard_cnt!=0 is consumed and decrements the counter. It is never delivered.
  - Saturate at 2^DISC_W-1.
- Flush (wb_flush=1):
  - Next cycle: ms_valid=0, state=IDLE, rdata_buf_v=0. Any bus acceptance that cycle is ignored.
  - discard_cnt += (state==WAIT && !(data_ok && discard_cnt==0)) + es_flush_req.
  - If a decrement happens in the same cycle, the increment and decrement net out.
- Load data: byte/half selected by addr_lo from the live or buffered rdata.
  - ld_op 000 = ld.w.
  - ld_op 001 = ld.b, sign-extended.
  - ld_op 010 = ld.bu, zero-extended.
  - ld_op 011 = ld.h, sign-extended, offset addr_lo[1]*2.
  - ld_op 100 = ld.hu, zero-extended.
  - Any other ld_op means non-load: final_result = alu_result.
  - Stores have req_issued=1 and ld_op=111. They wait for data_ok, then forward alu_result.
- pending_load = ms_valid && req_issued && ld_op is a load && !ms_ready_go. ID must stall on a dest match.

Optional Feature:
- MS_PERF_CNT_EN:
  - Adds output perf_ld_wait [31:0]. It increments each cycle ms_valid && state==WAIT && !ms_ready_go, resets to 0 and wraps at 2^32.
  - Without the macro the port is absent and no counter logic exists.

Test Plan:
- ld.b, addr_lo=3, rdata=0x80FF_0000, data_ok 2 cycles after accept, ws_allowin=1:
  - final_result=0xFFFF_FF80; ms_to_ws_valid high exactly in the data_ok cycle; ms_allowin=0 in the 2 cycles before.
- ld.hu, addr_lo=2, rdata=0xBEEF_1234, ws_allowin held 0 for 3 cycles after data_ok:
  - HOLD entered, final_result=0x0000_BEEF stable for all 3 cycles; single handoff when ws_allowin rises.
- add, req_issued=0, alu_result=0x1234_5678, back-to-back with the next instruction:
  - 1-cycle throughput; final_result=0x1234_5678; pending_load=0.
- Load in WAIT, wb_flush with es_flush_req=1:
  - discard_cnt=2; next two data_ok (rdata 0x1, 0x2) dropped, ms_to_ws_valid stays 0; the third data_ok, for a new ld.w, delivers 0x3.
- resetn asserted mid-WAIT:
  - All outputs 0 and ms_allowin=1 immediately (async); after release the first data_ok with no instruction in flight is ignored and discard_cnt stays 0.
- MS_PERF_CNT_EN defined, load waits 5 cycles:
  - perf_ld_wait=5; macro undefined: design elaborates without the port.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: EXE->WB memory stage, tracks data-SRAM responses and extends loads.
// Optional: define MS_PERF_CNT_EN to add the perf_ld_wait load-wait counter.
module mem_stage #(
  parameter int PAY_W  = 103,
  parameter int DISC_W = 2
) (
  input  logic               clk,
  input  logic               resetn,
  output logic               ms_allowin,
  input  logic               es_to_ms_valid,
  input  logic [PAY_W+75:0]  es_to_ms_bus,
  input  logic               ws_allowin,
  output logic               ms_to_ws_valid,
  output logic [PAY_W+69:0]  ms_to_ws_bus,
  input  logic               data_sram_data_ok,
  input  logic [31:0]        data_sram_rdata,
  input  logic               wb_flush,
  input  logic               es_flush_req,
  output logic [39:0]        ms_fwd_bus
`ifdef MS_PERF_CNT_EN
  ,
  output logic [31:0]        perf_ld_wait
`endif
);

  localparam int CW = DISC_W + 2;

  typedef struct packed {
    logic [PAY_W-1:0] payload;
    logic [2:0]       ld_op;
    logic [1:0]       addr_lo;
    logic             req_issued;
    logic             gr_we;
    logic [4:0]       dest;
    logic [31:0]      alu_result;
    logic [31:0]      pc;
  } es_bus_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  es_bus_t           in_bus;
  es_bus_t           ms_r;
  state_t            state;
  state_t            state_n;
  logic              ms_valid;
  logic              ms_ready_go;
  logic              accept;
  logic              leave;
  logic              resp_live;
  logic              is_load;
  logic              pending_load;
  logic [DISC_W-1:0] discard_cnt;
  logic [DISC_W-1:0] discard_n;
  logic [CW-1:0]     cnt_sum;
  logic              inc_wait;
  logic              inc_es;
  logic              dec;
  logic              rdata_buf_v;
  logic [31:0]       rdata_buf;
  logic [31:0]       ld_src;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val;
  logic [31:0]       final_result;

  assign in_bus = es_to_ms_bus;

  assign resp_live = (state == WAIT)
                  && data_sram_data_ok
                  && (discard_cnt == '0);

  assign ms_ready_go = !ms_r.req_issued
                    || (state == HOLD)
                    || resp_live;

  assign ms_allowin = !ms_valid
                   || (ms_ready_go && ws_allowin);

  assign accept = es_to_ms_valid
               && ms_allowin
               && !wb_flush;

  assign leave = ms_valid
              && ms_ready_go
              && ws_allowin;

  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // Stage occupancy; flush drops whatever is here or arriving
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ms_valid <= 1'b0;
    else if (wb_flush)
      ms_valid <= 1'b0;
    else if (ms_allowin)
      ms_valid <= es_to_ms_valid;
  end

  // Captured EXE bus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      ms_r <= '0;
    else if (accept)
      ms_r <= in_bus;
  end

  // Response FSM state and buffered-data flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rdata_buf_v <= 1'b0;
    end else begin
      state       <= state_n;
      rdata_buf_v <= (state_n == HOLD);
    end
  end

  // Next state: a leaving or fresh entry restarts the tracking
  always_comb begin
    state_n = state;
    if (wb_flush)
      state_n = IDLE;
    else if (accept)
      state_n = in_bus.req_issued ? WAIT : IDLE;
    else if (leave)
      state_n = IDLE;
    else if (resp_live)
      state_n = HOLD;
  end

  // Hold read data while WB back-pressures
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rdata_buf <= '0;
    else if ((state == WAIT) && (state_n == HOLD))
      rdata_buf <= data_sram_rdata;
  end

  assign inc_wait = wb_flush && (state == WAIT) && !resp_live;
  assign inc_es   = wb_flush && es_flush_req;
  assign dec      = data_sram_data_ok && (discard_cnt != '0);

  // Count of stale responses still to be swallowed
  always_comb begin
    cnt_sum = CW'(discard_cnt)
            + CW'(inc_wait)
            + CW'(inc_es)
            - CW'(dec);
    if (cnt_sum > CW'({DISC_W{1'b1}}))
      discard_n = '1;
    else
      discard_n = cnt_sum[DISC_W-1:0];
  end

  // Discard counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      discard_cnt <= '0;
    else
      discard_cnt <= discard_n;
  end

  assign ld_src  = rdata_buf_v ? rdata_buf : data_sram_rdata;
  assign ld_half = ms_r.addr_lo[1] ? ld_src[31:16] : ld_src[15:0];

  // Byte lane select
  always_comb begin
    ld_byte = ld_src[7:0];
    unique case (ms_r.addr_lo)
      2'd0: ld_byte = ld_src[7:0];
      2'd1: ld_byte = ld_src[15:8];
      2'd2: ld_byte = ld_src[23:16];
      2'd3: ld_byte = ld_src[31:24];
    endcase
  end

  // Load extension; anything else forwards the ALU result
  always_comb begin
    ld_val = ms_r.alu_result;
    unique case (1'b1)
      ms_r.ld_op == 3'd0: ld_val = ld_src;
      ms_r.ld_op == 3'd1: ld_val = {{24{ld_byte[7]}}, ld_byte};
      ms_r.ld_op == 3'd2: ld_val = {24'd0, ld_byte};
      ms_r.ld_op == 3'd3: ld_val = {{16{ld_half[15]}}, ld_half};
      ms_r.ld_op == 3'd4: ld_val = {16'd0, ld_half};
      default:            ld_val = ms_r.alu_result;
    endcase
  end

  assign is_load      = (ms_r.ld_op <= 3'd4);
  assign final_result = ms_valid ? ld_val : 32'd0;

  assign pending_load = ms_valid
                     && ms_r.req_issued
                     && is_load
                     && !ms_ready_go;

  assign ms_to_ws_bus = {ms_r.payload,
                         ms_r.gr_we,
                         ms_r.dest,
                         final_result,
                         ms_r.pc};

  assign ms_fwd_bus = {ms_valid,
                       pending_load,
                       ms_r.gr_we & ms_valid,
                       ms_r.dest,
                       final_result};

`ifdef MS_PERF_CNT_EN
  // Cycles a valid entry spends waiting on its response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      perf_ld_wait <= '0;
    else if (ms_valid && (state == WAIT) && !ms_ready_go)
      perf_ld_wait <= perf_ld_wait + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized checks of mem_stage.
// Reference model is a transaction-level scoreboard of expected WB bundles.
module tb_mem_stage;

  localparam int PAY_W = 103;
  localparam int BW    = PAY_W + 76;
  localparam int OW    = PAY_W + 70;

  logic             clk;
  logic             resetn;
  logic             ms_allowin;
  logic             es_to_ms_valid;
  logic [BW-1:0]    es_to_ms_bus;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [OW-1:0]    ms_to_ws_bus;
  logic             data_ok;
  logic [31:0]      rdata;
  logic             wb_flush;
  logic             es_flush_req;
  logic [39:0]      ms_fwd_bus;
`ifdef MS_PERF_CNT_EN
  logic [31:0]      perf_ld_wait;
`endif

  int checks = 0;
  int errors = 0;

  mem_stage #(.PAY_W(PAY_W), .DISC_W(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata),
    .wb_flush          (wb_flush),
    .es_flush_req      (es_flush_req),
    .ms_fwd_bus        (ms_fwd_bus)
`ifdef MS_PERF_CNT_EN
    ,
    .perf_ld_wait      (perf_ld_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [191:0] obs,
                     input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(
    input logic [2:0]       op,
    input logic [1:0]       lo,
    input logic             req,
    input logic             we,
    input logic [4:0]       dst,
    input logic [31:0]      alu,
    input logic [31:0]      pc,
    input logic [PAY_W-1:0] pay);
    return {pay, op, lo, req, we, dst, alu, pc};
  endfunction

  function automatic logic [31:0] ref_ld(
    input logic [2:0]  op,
    input logic [1:0]  lo,
    input logic [31:0] rd,
    input logic [31:0] alu);
    logic [31:0] b;
    logic [31:0] h;
    b = (rd >> (8 * lo)) & 32'hFF;
    h = (rd >> (16 * lo[1])) & 32'hFFFF;
    case (op)
      3'd0: return rd;
      3'd1: return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd2: return b;
      3'd3: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4: return h;
      default: return alu;
    endcase
  endfunction

  task automatic idle();
    es_to_ms_valid = 1'b0;
    data_ok        = 1'b0;
    wb_flush       = 1'b0;
    es_flush_req   = 1'b0;
    rdata          = $urandom;
  endtask

  logic [PAY_W-1:0] pay;
  int               hand;
  logic [31:0]      p0;

  logic             mv, mreq, mgot, pend, exp_go, exp_allow;
  int               dly;
  logic [31:0]      pdata;
  logic [OW-1:0]    mexp;
  logic [2:0]       c_op;
  logic [1:0]       c_lo;
  logic             c_req, c_we;
  logic [4:0]       c_dst;
  logic [31:0]      c_alu, c_pc;
  logic [PAY_W-1:0] c_pay;
  int               kind;

  task automatic new_cand();
    kind  = $urandom_range(0, 2);
    c_lo  = 2'($urandom);
    c_we  = 1'($urandom);
    c_dst = 5'($urandom);
    c_alu = $urandom;
    c_pc  = $urandom;
    c_pay = PAY_W'({$urandom, $urandom, $urandom, $urandom});
    if (kind == 0) begin
      c_op  = 3'($urandom_range(0, 4));
      c_req = 1'b1;
    end else if (kind == 1) begin
      c_op  = 3'd7;
      c_req = 1'b1;
    end else begin
      c_op  = 3'($urandom_range(5, 7));
      c_req = 1'b0;
    end
  endtask

  initial begin
    p0     = '0;
    resetn = 1'b0;
    ws_allowin   = 1'b1;
    es_to_ms_bus = '0;
    idle();
    pay = PAY_W'({$urandom, $urandom, $urandom, $urandom});
    #1;
    chk("rst_allowin", ms_allowin, 1);
    chk("rst_valid", ms_to_ws_valid, 0);
    chk("rst_fwd", ms_fwd_bus, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // ld.b addr_lo=3
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd1, 2'd3, 1, 1, 5'd5, 32'h100, 32'h1c00_0000, pay);
    #1 chk("t1_allow_acc", ms_allowin, 1);
    @(negedge clk);
    idle();
    #1;
    chk("t1_allow_w1", ms_allowin, 0);
    chk("t1_valid_w1", ms_to_ws_valid, 0);
    chk("t1_pend_w1", ms_fwd_bus[38], 1);
    @(negedge clk);
    #1;
    chk("t1_allow_w2", ms_allowin, 0);
    chk("t1_valid_w2", ms_to_ws_valid, 0);
    @(negedge clk);
    data_ok = 1'b1;
    rdata   = 32'h80FF_0000;
    #1;
    chk("t1_valid_ok", ms_to_ws_valid, 1);
    chk("t1_final", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    chk("t1_fwd_res", ms_fwd_bus[31:0], 32'hFFFF_FF80);
    chk("t1_pend_ok", ms_fwd_bus[38], 0);
    chk("t1_allow_ok", ms_allowin, 1);
    @(negedge clk);
    idle();
    #1 chk("t1_valid_after", ms_to_ws_valid, 0);

    // ld.hu addr_lo=2 with WB back-pressure
    hand = 0;
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd4, 2'd2, 1, 1, 5'd6, 32'h202, 32'h1c00_0004, pay);
    @(negedge clk);
    idle();
    data_ok    = 1'b1;
    rdata      = 32'hBEEF_1234;
    ws_allowin = 1'b0;
    #1;
    chk("t2_valid_ok", ms_to_ws_valid, 1);
    chk("t2_final_ok", ms_to_ws_bus[63:32], 32'h0000_BEEF);
    chk("t2_allow_ok", ms_allowin, 0);
    if (ms_to_ws_valid && ws_allowin) hand++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle();
      #1;
      chk("t2_hold_valid", ms_to_ws_valid, 1);
      chk("t2_hold_final", ms_to_ws_bus[63:32], 32'h0000_BEEF);
      chk("t2_hold_buf", dut.rdata_buf_v, 1);
      if (ms_to_ws_valid && ws_allowin) hand++;
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    chk("t2_rel_final", ms_to_ws_bus[63:32], 32'h0000_BEEF);
    if (ms_to_ws_valid && ws_allowin) hand++;
    @(negedge clk);
    #1;
    if (ms_to_ws_valid && ws_allowin) hand++;
    chk("t2_valid_after", ms_to_ws_valid, 0);
    chk("t2_handoffs", hand, 1);

    // back-to-back ALU ops
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd7, 2'd0, 0, 1, 5'd1, 32'h1234_5678, 32'h1c00_0008, pay);
    @(negedge clk);
    es_to_ms_bus = mk(3'd7, 2'd0, 0, 1, 5'd2, 32'h9ABC_DEF0, 32'h1c00_000c, pay);
    #1;
    chk("t3_valid1", ms_to_ws_valid, 1);
    chk("t3_final1", ms_to_ws_bus[63:32], 32'h1234_5678);
    chk("t3_pend1", ms_fwd_bus[38], 0);
    chk("t3_allow1", ms_allowin, 1);
    @(negedge clk);
    idle();
    #1;
    chk("t3_valid2", ms_to_ws_valid, 1);
    chk("t3_final2", ms_to_ws_bus[63:32], 32'h9ABC_DEF0);
    chk("t3_dest2", ms_fwd_bus[36:32], 5'd2);
    @(negedge clk);
    #1 chk("t3_valid_after", ms_to_ws_valid, 0);

    // flush while waiting, plus an EXE-side flushed request
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 2'd0, 1, 1, 5'd7, 32'h300, 32'h1c00_0010, pay);
    @(negedge clk);
    es_to_ms_bus = mk(3'd0, 2'd0, 1, 1, 5'd8, 32'h304, 32'h1c00_0014, pay);
    wb_flush     = 1'b1;
    es_flush_req = 1'b1;
    #1 chk("t4_valid_fl", ms_to_ws_valid, 0);
    @(negedge clk);
    idle();
    #1;
    chk("t4_dcnt", dut.discard_cnt, 2);
    chk("t4_valid_post", ms_to_ws_valid, 0);
    chk("t4_allow_post", ms_allowin, 1);
    @(negedge clk);
    data_ok = 1'b1;
    rdata   = 32'h1;
    #1 chk("t4_drop1", ms_to_ws_valid, 0);
    @(negedge clk);
    rdata = 32'h2;
    #1 chk("t4_drop2", ms_to_ws_valid, 0);
    @(negedge clk);
    idle();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 2'd0, 1, 1, 5'd9, 32'h308, 32'h1c00_0018, pay);
    #1 chk("t4_dcnt_zero", dut.discard_cnt, 0);
    @(negedge clk);
    idle();
    data_ok = 1'b1;
    rdata   = 32'h3;
    #1;
    chk("t4_deliver_v", ms_to_ws_valid, 1);
    chk("t4_deliver_d", ms_to_ws_bus[63:32], 32'h3);
    @(negedge clk);
    idle();
    #1 chk("t4_valid_after", ms_to_ws_valid, 0);

    // async reset mid-WAIT
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd0, 2'd1, 1, 1, 5'd10, 32'h400, 32'h1c00_001c, pay);
    @(negedge clk);
    idle();
    #1 chk("t5_allow_wait", ms_allowin, 0);
    #2 resetn = 1'b0;
    #1;
    chk("t5_rst_allow", ms_allowin, 1);
    chk("t5_rst_valid", ms_to_ws_valid, 0);
    chk("t5_rst_fwd", ms_fwd_bus, 0);
    chk("t5_rst_bus", ms_to_ws_bus, 0);
    @(negedge clk);
    resetn  = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    #1 chk("t5_stray_valid", ms_to_ws_valid, 0);
    @(negedge clk);
    idle();
    #1;
    chk("t5_dcnt", dut.discard_cnt, 0);
    chk("t5_allow", ms_allowin, 1);
    chk("t5_valid", ms_to_ws_valid, 0);

    // ld.h waiting 5 cycles
`ifdef MS_PERF_CNT_EN
    p0 = perf_ld_wait;
`endif
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(3'd3, 2'd2, 1, 1, 5'd11, 32'h500, 32'h1c00_0020, pay);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle();
      #1 chk("t6_pend", ms_fwd_bus[38], 1);
    end
    @(negedge clk);
    data_ok = 1'b1;
    rdata   = 32'h8001_0000;
    #1;
    chk("t6_valid", ms_to_ws_valid, 1);
    chk("t6_final", ms_to_ws_bus[63:32], 32'hFFFF_8001);
    @(negedge clk);
    idle();
    #1;
    chk("t6_valid_after", ms_to_ws_valid, 0);
`ifdef MS_PERF_CNT_EN
    chk("t6_perf", perf_ld_wait - p0, 5);
`endif

    // randomized traffic against the scoreboard
    mv   = 1'b0;
    mreq = 1'b0;
    mgot = 1'b0;
    pend = 1'b0;
    dly  = 0;
    pdata = '0;
    mexp  = '0;
    new_cand();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      data_ok = pend && (dly == 0);
      rdata   = data_ok ? pdata : $urandom;
      ws_allowin     = ($urandom_range(0, 3) != 0);
      es_to_ms_valid = 1'($urandom_range(0, 1));
      es_to_ms_bus   = mk(c_op, c_lo, c_req, c_we, c_dst, c_alu, c_pc, c_pay);
      #1;
      exp_go    = mv && (!mreq || mgot || data_ok);
      exp_allow = !mv || (exp_go && ws_allowin);
      chk("r_valid", ms_to_ws_valid, exp_go);
      chk("r_allow", ms_allowin, exp_allow);
      if (exp_go && ws_allowin) begin
        chk("r_bus", ms_to_ws_bus, mexp);
        mv = 1'b0;
      end
      if (data_ok) begin
        pend = 1'b0;
        mgot = 1'b1;
      end else if (pend) begin
        dly--;
      end
      if (es_to_ms_valid && exp_allow) begin
        mv    = 1'b1;
        mreq  = c_req;
        mgot  = 1'b0;
        pdata = $urandom;
        if (c_req) begin
          pend = 1'b1;
          dly  = $urandom_range(0, 3);
        end
        mexp = {c_pay, c_we, c_dst, ref_ld(c_op, c_lo, pdata, c_alu), c_pc};
        new_cand();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
